// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared half-precision definitions for the FPU and its
//               integer front-end converter: field widths, exponent bias,
//               the converter state encoding and the packed fp16 operand
//               layout {sign, exp, man} used for Asem/Bsem/Rsem.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;
  localparam int EXP_BIAS = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_PACK = 2'd2,
    S_DONE = 2'd3
  } cvt_state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

endpackage
`default_nettype wire

// File: rtl/fp16_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp16_round_pack
// Description : Combinational back end of the int16 -> fp16 converter.
//               Takes a normalised magnitude (MSB set unless zero), the
//               number of left shifts applied, the sign and a zero flag,
//               and returns the packed half-precision word.
//               Optional macro INT16_TO_FP16_RNE_EN selects round to
//               nearest, ties to even; otherwise the result is truncated.
// Ports       : i_sign      - sign of the original integer
//               i_shift_cnt - left shifts applied during normalisation
//               i_mag       - normalised 16-bit magnitude
//               i_zero      - operand was zero
//               o_rsem      - packed fp16 result
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_round_pack
  import fpu_pkg::*;
#(
  parameter int EXP_BIAS = 15,
  parameter int MAN_W    = 10
) (
  input  logic        i_sign,
  input  logic [3:0]  i_shift_cnt,
  input  logic [15:0] i_mag,
  input  logic        i_zero,
  output logic [15:0] o_rsem
);

  // Exponent of a magnitude whose MSB sits at bit 15 without any shift.
  localparam int EXP_TOP = EXP_BIAS + 15;

  logic [EXP_W-1:0] w_exp_base;
  logic [MAN_W-1:0] w_man;
  logic [EXP_W-1:0] w_exp_final;
  logic [MAN_W-1:0] w_man_final;
  fp16_t            w_res;

  assign w_exp_base = EXP_W'(EXP_TOP) - EXP_W'(i_shift_cnt);
  // Bit 15 is the hidden leading one and is not stored.
  assign w_man      = i_mag[14 -: MAN_W];

`ifdef INT16_TO_FP16_RNE_EN
  logic           w_guard;
  logic           w_sticky;
  logic           w_up;
  logic [MAN_W:0] w_sum;
  logic           w_unused_msb;

  assign w_guard  = i_mag[14-MAN_W];
  assign w_sticky = |i_mag[13-MAN_W:0];
  assign w_up     = w_guard & (w_sticky | w_man[0]);
  assign w_sum    = {1'b0, w_man} + {{MAN_W{1'b0}}, w_up};
  // A carry out leaves the stored mantissa at zero and bumps the exponent;
  // the largest magnitude only reaches exponent 30 so no overflow handling.
  assign w_man_final  = w_sum[MAN_W-1:0];
  assign w_exp_final  = w_exp_base + EXP_W'(w_sum[MAN_W]);
  assign w_unused_msb = i_mag[15];
`else
  logic w_unused_bits;

  assign w_man_final   = w_man;
  assign w_exp_final   = w_exp_base;
  assign w_unused_bits = ^{i_mag[15], i_mag[14-MAN_W:0]};
`endif

  always_comb begin
    w_res = '0;
    if (!i_zero) begin
      w_res.sign = i_sign;
      w_res.exp  = w_exp_final;
      w_res.man  = w_man_final;
    end
  end

  assign o_rsem = w_res;

endmodule
`default_nettype wire

// File: rtl/int16_to_fp16.sv
`default_nettype none
// ============================================================================
// Module      : int16_to_fp16
// Description : Sequential 16-bit two's-complement integer to IEEE 754
//               half-precision converter. Normalises one bit per cycle,
//               then rounds/packs. Valid/ready handshake on both sides; no
//               overlap between conversions.
//               Optional macro INT16_TO_FP16_RNE_EN enables round to
//               nearest even (default: truncate toward zero).
// Ports       : clk, rst_n (async, active-low)
//               in_valid / in_ready / int_in    - integer operand input
//               out_valid / out_ready / Rsem    - fp16 result output
// Revision    : 1.0 - initial release
// ============================================================================
module int16_to_fp16
  import fpu_pkg::*;
#(
  parameter int EXP_BIAS = 15,
  parameter int MAN_W    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] int_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Rsem
);

  cvt_state_t  r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_rsem;
  logic        r_sign;
  logic [15:0] r_mag;
  logic [3:0]  r_shift_cnt;
  logic        r_zero;

  logic [15:0] w_abs;
  logic [15:0] w_packed;

  // -32768 wraps to 0x8000, which is the correct unsigned magnitude.
  assign w_abs = int_in[15] ? (~int_in + 16'd1) : int_in;

  fp16_round_pack #(
    .EXP_BIAS (EXP_BIAS),
    .MAN_W    (MAN_W)
  ) u_round_pack (
    .i_sign      (r_sign),
    .i_shift_cnt (r_shift_cnt),
    .i_mag       (r_mag),
    .i_zero      (r_zero),
    .o_rsem      (w_packed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_rsem      <= 16'h0000;
      r_sign      <= 1'b0;
      r_mag       <= 16'h0000;
      r_shift_cnt <= 4'd0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign      <= int_in[15];
            r_mag       <= w_abs;
            r_shift_cnt <= 4'd0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_state     <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_mag == 16'h0000) begin
            r_zero  <= 1'b1;
            r_state <= S_PACK;
          end else if (!r_mag[15]) begin
            r_mag       <= {r_mag[14:0], 1'b0};
            r_shift_cnt <= r_shift_cnt + 4'd1;
          end else begin
            r_state <= S_PACK;
          end
        end
        S_PACK: begin
          r_rsem      <= w_packed;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Rsem      = r_rsem;

endmodule
`default_nettype wire

// File: tb/tb_int16_to_fp16.sv
`default_nettype none
// ============================================================================
// Module      : tb_int16_to_fp16
// Description : Directed self-checking bench for int16_to_fp16. Expected
//               results and latencies are hand-computed; rounding-dependent
//               vectors follow INT16_TO_FP16_RNE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int16_to_fp16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] int_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Rsem;

  int checks;
  int errors;

  int16_to_fp16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .int_in    (int_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Rsem      (Rsem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present an operand for one accept edge; returns #1 after that edge.
  task automatic start(input logic [15:0] v);
    @(posedge clk); #1;
    in_valid = 1'b1;
    int_in   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until out_valid, bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovalid_low"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_iready_high"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic convert(input string tag, input logic [15:0] v,
                         input logic [15:0] exp_r, input int exp_lat);
    int lat;
    check({tag, "_iready"}, {31'd0, in_ready}, 32'd1);
    start(v);
    wait_result(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rsem"}, {16'd0, Rsem}, {16'd0, exp_r});
    handshake(tag);
  endtask

  initial begin
    logic [15:0] held;
    int lat;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    int_in    = 16'h0000;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ovalid", {31'd0, out_valid}, 32'd0);
    check("reset_rsem", {16'd0, Rsem}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_iready", {31'd0, in_ready}, 32'd1);

    convert("one",      16'h0001, 16'h3C00, 17);
    convert("minus1",   16'hFFFF, 16'hBC00, 17);
    convert("zero",     16'h0000, 16'h0000, 2);
    convert("min_neg",  16'h8000, 16'hF800, 2);
`ifdef INT16_TO_FP16_RNE_EN
    convert("max_pos",  16'h7FFF, 16'h7800, 3);
    convert("tie_even", 16'd2049, 16'h6800, 6);
    convert("tie_up",   16'd2051, 16'h6802, 6);
`else
    convert("max_pos",  16'h7FFF, 16'h77FF, 3);
    convert("trunc_2051", 16'd2051, 16'h6801, 6);
`endif
    convert("three",    16'h0003, 16'h4200, 16);
    convert("minus100", 16'hFF9C, 16'hD640, 11);

    // Back-pressure: result held, input side blocked, stray in_valid ignored.
    start(16'h0005);
    wait_result(lat);
    check("bp_latency", lat, 15);
    held = Rsem;
    check("bp_rsem", {16'd0, held}, 32'h4500);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        int_in   = 16'h0007;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("bp_hold_rsem", {16'd0, Rsem}, {16'd0, held});
      check("bp_hold_iready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_ovalid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    handshake("bp_release");
    // The stray pulse must not have started a conversion.
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_stray_ovalid", {31'd0, out_valid}, 32'd0);
    check("bp_no_stray_iready", {31'd0, in_ready}, 32'd1);

    // Abort during normalisation of input 1.
    start(16'h0001);
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_ovalid", {31'd0, out_valid}, 32'd0);
    check("abort_rsem", {16'd0, Rsem}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    convert("after_abort", 16'h0003, 16'h4200, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int16_to_fp16.md
# int16_to_fp16

Sequential converter from 16-bit two's-complement integers to IEEE 754 half-precision words in the `{sign, 5-bit exponent, 10-bit mantissa}` format used by `FPU` operands (`Asem`/`Bsem`). It sits in front of the FPU and turns integer sources into FPU-ready operands. It uses an iterative one-bit-per-cycle normaliser with a valid/ready handshake on both sides.

## Interface
Parameters:
- `EXP_BIAS`, default 15: half-precision exponent bias.
- `MAN_W`, default 10: mantissa width. Fixed by the format; must not be overridden.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: `int_in` is valid.
- `in_ready`, output, 1: converter is idle and can accept.
- `int_in`, input, 16: signed integer operand.
- `out_valid`, output, 1: `Rsem` holds a result.
- `out_ready`, input, 1: consumer takes the result.
- `Rsem`, output, 16: half-precision result.

## Operation
- State machine states: IDLE, NORM, PACK, DONE.
- `in_ready` = (state == IDLE).
- An accept occurs on a rising edge with `in_valid && in_ready`. On accept:
  - latch `sign = int_in[15]`;
  - latch `mag = |int_in|` as 16-bit unsigned (-32768 gives 0x8000);
  - clear `shift_cnt` (4 bits);
  - go to NORM.
- In NORM, each cycle:
  - if `mag == 0`, go to PACK with a zero flag;
  - else if `mag[15] == 0`, shift `mag` left by 1 and increment `shift_cnt`;
  - else go to PACK.
- In PACK:
  - exponent = 30 − `shift_cnt`;
  - mantissa = `mag[14:5]`, guard = `mag[4]`, sticky = OR of `mag[3:0]`;
  - apply rounding (see Configuration);
  - mantissa carry-out sets the mantissa to 0 and increments the exponent (largest result is exponent 30; overflow is impossible);
  - zero flag forces `Rsem = 0x0000`, so -0 is never produced;
  - register `Rsem` and go to DONE.
- In DONE:
  - `out_valid` = 1;
  - `Rsem` is held stable until `out_valid && out_ready` on an edge, then go to IDLE;
  - `in_valid` is ignored while not IDLE.
- Reset values: state IDLE, `in_ready` 1 (once out of reset), `out_valid` 0, `Rsem` 0x0000, internal registers 0.
- Asserting `rst_n` low mid-conversion aborts immediately. The in-flight operand is discarded.

## Timing
- Let N = leading-zero count of `mag` (0..15). A zero input behaves as N = 0.
- Edge sequence after the accept edge E0:
  - E1..EN shift;
  - E(N+1) moves NORM→PACK;
  - E(N+2) moves PACK→DONE, and `out_valid` rises after it.
- Latency: N+2 cycles from accept to `out_valid`. Minimum 2 (for 0 and |x| ≥ 32768), maximum 17 (for ±1).
- No back-to-back overlap: the next accept is possible on the edge after the output handshake (IDLE re-entered).
- With `out_ready` tied high, throughput is one result per N+4 cycles.
- `out_ready` asserted before `out_valid` has no effect.

## Configuration
- Macro `INT16_TO_FP16_RNE_EN`:
  - Defined: round to nearest, ties to even. Round up iff `guard && (sticky || mantissa[0])`.
  - Undefined: truncate toward zero. Guard and sticky are ignored and no carry path is synthesised.

## Structure
- Shared package `fpu_pkg` holds:
  - half-precision field widths (`EXP_W` = 5, `MAN_W` = 10);
  - `EXP_BIAS` = 15;
  - the state enum typedef `cvt_state_t`;
  - the `fp16_t` packed-struct typedef `{sign, exp, man}`, shared with `FPU`.
- One sub-module, `fp16_round_pack`. It is combinational: it takes sign, `shift_cnt`, `mag` and the zero flag, and returns the packed 16-bit word. It contains the `INT16_TO_FP16_RNE_EN` logic.

## Test plan
- 1 → `Rsem` 0x3C00 with `out_valid` 17 cycles after accept. -1 → 0xBC00.
- 0 → 0x0000 after 2 cycles. -32768 → 0xF800 after 2 cycles.
- 32767 → 0x7800 with `INT16_TO_FP16_RNE_EN` defined, 0x77FF without it.
- 2049 → 0x6800 (tie, round to even, no increment). 2051 → 0x6802 (tie, round up to even). Both with `INT16_TO_FP16_RNE_EN` defined.
- `out_ready` held low for 5 cycles after `out_valid`:
  - `Rsem` stays stable;
  - `in_ready` stays 0;
  - a new `in_valid` pulse is ignored;
  - releasing `out_ready` returns to IDLE on the next edge.
- `rst_n` pulsed low during NORM of input 1:
  - outputs return immediately to `out_valid` 0, `Rsem` 0x0000;
  - a following conversion of 3 yields 0x4200.
